// File: rtl/i2c_pkg.sv
// Shared states, bus constants and the majority helper for the I2C register-access target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_e;

  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic ACK          = 1'b0;
  localparam logic NACK         = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA synchroniser with optional 3-sample majority filter (I2C_SLAVE_GLITCH_FILTER_EN),
// producing single-cycle SCL rise/fall and START/STOP strobes.
module i2c_line_cond
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s, scl_c, sda_c;
  logic                   scl_prv_q, sda_prv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prv_q  <= 1'b1;
      sda_prv_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prv_q  <= scl_c;
      sda_prv_q  <= sda_c;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  // Vote over the newest sample and two held ones: one clk of latency, 1-clk spikes vanish.
  logic [1:0] scl_h_q, sda_h_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_h_q <= '1;
      sda_h_q <= '1;
    end else begin
      scl_h_q <= {scl_h_q[0], scl_s};
      sda_h_q <= {sda_h_q[0], sda_s};
    end
  end

  assign scl_c = maj3(scl_s, scl_h_q[0], scl_h_q[1]);
  assign sda_c = maj3(sda_s, sda_h_q[0], sda_h_q[1]);
`else
  assign scl_c = scl_s;
  assign sda_c = sda_s;
`endif

  assign sda_lvl_o  = sda_c;
  assign scl_rise_o = scl_c & ~scl_prv_q;
  assign scl_fall_o = ~scl_c & scl_prv_q;
  assign start_o    = scl_c & scl_prv_q & sda_prv_q & ~sda_c;
  assign stop_o     = scl_c & scl_prv_q & ~sda_prv_q & sda_c;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with 8-bit register pointer and byte-wide register port; open-drain SDA, no stretching.
// Build with I2C_SLAVE_GLITCH_FILTER_EN to add majority filtering on SCL/SDA.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       addr_hit
);

  logic sda_lvl, rise, fall, start_ev, stop_ev;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line_cond (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_lvl_o (sda_lvl),
    .scl_rise_o(rise),
    .scl_fall_o(fall),
    .start_o   (start_ev),
    .stop_o    (stop_ev)
  );

  state_e     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d, addr_q, addr_d, wdata_q, wdata_d, byte_in;
  logic       wr_q, wr_d, rd_q, rd_d, rd_ld_q, hit_q, hit_d, busy_q, busy_d;
  logic       oen_q, oen_d, rw_q, rw_d, ptr_done_q, ptr_done_d, rd_first_q, rd_first_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      rd_ld_q    <= 1'b0;
      hit_q      <= 1'b0;
      busy_q     <= 1'b0;
      oen_q      <= 1'b1;
      rw_q       <= I2C_RW_WRITE;
      ptr_done_q <= 1'b0;
      rd_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      rd_ld_q    <= rd_q;
      hit_q      <= hit_d;
      busy_q     <= busy_d;
      oen_q      <= oen_d;
      rw_q       <= rw_d;
      ptr_done_q <= ptr_done_d;
      rd_first_q <= rd_first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    hit_d      = 1'b0;
    busy_d     = busy_q;
    oen_d      = oen_q;
    rw_d       = rw_q;
    ptr_done_d = ptr_done_q;
    rd_first_d = rd_first_q;
    byte_in    = {shift_q[6:0], sda_lvl};

    if (wr_q) addr_d = addr_q + 8'd1;
    // Read data lands two clks after reg_rd; the first byte's SCL fall has already passed, so drive now.
    if (rd_ld_q) begin
      shift_d = reg_rdata;
      if (rd_first_q) begin
        oen_d      = reg_rdata[7];
        shift_d    = {reg_rdata[6:0], 1'b0};
        bitcnt_d   = 4'd1;
        rd_first_d = 1'b0;
      end
    end

    if (stop_ev) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      oen_d      = 1'b1;
      rd_first_d = 1'b0;
    end else if (start_ev) begin
      state_d    = ADDR;
      busy_d     = 1'b1;
      oen_d      = 1'b1;
      bitcnt_d   = '0;
      rd_first_d = 1'b0;
      if (!busy_q) ptr_done_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, PTR, WDATA: if (rise) begin
          shift_d  = byte_in;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            bitcnt_d = '0;
            if (state_q == ADDR) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                hit_d   = 1'b1;
                rw_d    = byte_in[0];
                state_d = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end else if (state_q == PTR) begin
              addr_d     = byte_in;
              ptr_done_d = 1'b1;
              state_d    = PTR_ACK;
            end else begin
              wdata_d = byte_in;
              wr_d    = 1'b1;
              state_d = WDATA_ACK;
            end
          end
        end
        // SDA is released on entry, so the first fall starts the ACK and the second ends it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (fall) begin
          if (oen_q) begin
            oen_d = ACK;
          end else begin
            oen_d    = 1'b1;
            bitcnt_d = '0;
            if (state_q != ADDR_ACK) begin
              state_d = WDATA;
            end else if (rw_q == I2C_RW_READ) begin
              rd_d       = 1'b1;
              rd_first_d = 1'b1;
              state_d    = RDATA;
            end else begin
              state_d = ptr_done_q ? WDATA : PTR;
            end
          end
        end
        RDATA: if (fall) begin
          if (bitcnt_q == 4'd8) begin
            oen_d   = 1'b1;
            state_d = RDATA_ACK;
          end else begin
            oen_d    = shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
        RDATA_ACK: if (rise) begin
          addr_d   = addr_q + 8'd1;
          bitcnt_d = '0;
          if (sda_lvl == ACK) begin
            rd_d    = 1'b1;
            state_d = RDATA;
          end else begin
            state_d = IGNORE;
          end
        end
        IGNORE:  oen_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign sda_o     = 1'b0;
  assign sda_oen   = oen_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign reg_rd    = rd_q;
  assign busy      = busy_q;
  assign addr_hit  = hit_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench: bit-banged I2C master, register bank, and pointer/memory reference model.
module tb_i2c_slave_regs;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst, scl_m, sda_m, sda_line;
  logic       sda_o, sda_oen, reg_wr, reg_rd, busy, addr_hit;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  logic [7:0]  bank [256];
  logic [7:0]  model_mem [256];
  logic [15:0] wr_log [$];
  logic [15:0] exp_wr [$];
  int          wr_idx = 0;
  int          rd_cnt = 0, hit_cnt = 0, both_cnt = 0, oen_low_cnt = 0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign sda_line  = sda_m & (sda_oen ? 1'b1 : sda_o);
  assign reg_rdata = bank[reg_addr];

  i2c_slave_regs dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_o(sda_o), .sda_oen(sda_oen), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .busy(busy), .addr_hit(addr_hit)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 'h20) return 8'h3C;
    if (i == 'h21) return 8'h7E;
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Register bank plus event counters, all owned by this single process.
  initial begin
    for (int i = 0; i < 256; i++) bank[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (reg_wr) begin
        wr_log.push_back({reg_addr, reg_wdata});
        bank[reg_addr] = reg_wdata;
      end
      if (reg_rd) rd_cnt++;
      if (addr_hit) hit_cnt++;
      if (reg_wr && reg_rd) both_cnt++;
      if (!sda_oen) oen_low_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b, input bit glitch);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(Q);
    if (glitch) begin
      scl_m = 1'b0; tick(1);
      scl_m = 1'b1;
    end
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i], 1'b0);
    read_bit(ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] v);
    for (int i = 7; i >= 0; i--) read_bit(v[i]);
    write_bit(nack, 1'b0);
  endtask

  function automatic logic [7:0] glitch_byte(input logic [7:0] b, input int idx);
    logic [8:0] s = '0;
    int         j = 0;
    for (int i = 0; i < 8; i++) begin
      s[8-j] = b[7-i]; j++;
      if (i == idx) begin s[8-j] = b[7-i]; j++; end
    end
    return s[8:1];
  endfunction

  task automatic check_writes(input string tag);
    int n = wr_log.size() - wr_idx;
    chk($sformatf("%s_wr_count", tag), 32'(n), 32'(exp_wr.size()));
    for (int k = 0; k < n && k < exp_wr.size(); k++)
      chk($sformatf("%s_wr%0d", tag, k), 32'(wr_log[wr_idx+k]), 32'(exp_wr[k]));
    wr_idx = wr_log.size();
    exp_wr.delete();
  endtask

  task automatic write_txn(input string tag, input logic [7:0] ptr, input int n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d [3];
    logic [7:0] p = ptr;
    logic       ack;
    int         h0 = hit_cnt;
    d[0] = d0; d[1] = d1; d[2] = d2;
    i2c_start();
    wr_byte(8'hA0, ack); chk({tag, "_ack_addr"}, 32'(ack), 0);
    wr_byte(ptr, ack);   chk({tag, "_ack_ptr"}, 32'(ack), 0);
    for (int k = 0; k < n; k++) begin
      wr_byte(d[k], ack);
      chk($sformatf("%s_ack_d%0d", tag, k), 32'(ack), 0);
      exp_wr.push_back({p, d[k]});
      model_mem[p] = d[k];
      p = p + 8'd1;
    end
    chk({tag, "_busy_mid"}, 32'(busy), 1);
    i2c_stop();
    tick(4);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_addr_hit"}, 32'(hit_cnt - h0), 1);
    check_writes(tag);
  endtask

  task automatic read_txn(input string tag, input logic [7:0] ptr, input int n);
    logic [7:0] p = ptr;
    logic [7:0] v;
    logic       ack;
    int         r0 = rd_cnt;
    i2c_start();
    wr_byte(8'hA0, ack); chk({tag, "_ack_addr"}, 32'(ack), 0);
    wr_byte(ptr, ack);   chk({tag, "_ack_ptr"}, 32'(ack), 0);
    i2c_start();
    wr_byte(8'hA1, ack); chk({tag, "_ack_raddr"}, 32'(ack), 0);
    for (int k = 0; k < n; k++) begin
      rd_byte(k == n - 1, v);
      chk($sformatf("%s_rdata%0d", tag, k), 32'(v), 32'(model_mem[p]));
      p = p + 8'd1;
    end
    i2c_stop();
    tick(4);
    chk({tag, "_rd_count"}, 32'(rd_cnt - r0), 32'(n));
    check_writes(tag);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rp, wd0, wd1, wd2;
    int         s_hit, s_rd, s_oen, wn, rn, k;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
    tick(3);
    chk("rst_sda_oen", 32'(sda_oen), 1);
    chk("rst_sda_o", 32'(sda_o), 0);
    chk("rst_reg_addr", 32'(reg_addr), 0);
    chk("rst_reg_wdata", 32'(reg_wdata), 0);
    chk("rst_strobes", {29'd0, reg_wr, reg_rd, addr_hit}, 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick(10);

    write_txn("wr_ptr", 8'h10, 2, 8'h5A, 8'hC3, 8'h00);
    read_txn("rand_rd", 8'h20, 2);

    s_hit = hit_cnt; s_rd = rd_cnt; s_oen = oen_low_cnt;
    i2c_start();
    wr_byte(8'hB0, ack); chk("miss_nack", 32'(ack), 1);
    wr_byte(8'h01, ack);
    i2c_stop(); tick(4);
    chk("miss_no_hit", 32'(hit_cnt - s_hit), 0);
    chk("miss_no_rd", 32'(rd_cnt - s_rd), 0);
    chk("miss_sda_never_low", 32'(oen_low_cnt - s_oen), 0);
    check_writes("miss");

    write_txn("wrap", 8'hFF, 2, 8'h11, 8'h22, 8'h00);

    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) write_bit(1'(i & 1), 1'b0);
    i2c_stop(); tick(4);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sda_oen", 32'(sda_oen), 1);
    check_writes("abort");

    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'hA0 >> i), 1'b0);
    k = 0;
    while (sda_oen !== 1'b0 && k < 50) begin tick(1); k++; end
    chk("rst_ack_driven", 32'(sda_oen), 0);
    rst = 1'b1; #1;
    chk("rst_async_release", 32'(sda_oen), 1);
    tick(2);
    rst = 1'b0;
    i2c_stop(); tick(4);
    chk("rst_busy_after", 32'(busy), 0);

    for (int t = 0; t < 6; t++) begin
      rp  = 8'($urandom_range(0, 255));
      wn  = $urandom_range(1, 3);
      wd0 = 8'($urandom); wd1 = 8'($urandom); wd2 = 8'($urandom);
      write_txn($sformatf("rnd_wr%0d", t), rp, wn, wd0, wd1, wd2);
      rn = $urandom_range(1, 3);
      if (t[0]) rp = 8'($urandom_range(0, 255));
      read_txn($sformatf("rnd_rd%0d", t), rp, rn);
    end

    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h40, ack);
    for (int i = 0; i < 8; i++) write_bit(1'(8'h5A >> (7 - i)), i == 2);
    read_bit(ack);
    i2c_stop(); tick(4);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    exp_wr.push_back({8'h40, 8'h5A});
`else
    exp_wr.push_back({8'h40, glitch_byte(8'h5A, 2)});
`endif
    check_writes("glitch");

    chk("no_wr_rd_overlap", 32'(both_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder) for the PL I2C master: 7-bit address, 8-bit register pointer, byte-wide register access port toward the local register bank.
- Serves the master's transaction shapes:
  - Write: START, addr+W, pointer, data…, STOP.
  - Read: START, addr+W, pointer, Sr, addr+R, data…, NACK, STOP.
- Samples SCL/SDA on the system clock. Drives SDA only (open-drain). No clock stretching.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address matched against the first byte's [7:1].
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers (min 2).

Ports:
- clk  in  1  system clock; must be ≥16× SCL frequency
- rst  in  1  reset
- scl_i  in  1  SCL line input
- sda_i  in  1  SDA line input
- sda_o  out  1  SDA output value, constant 1'b0
- sda_oen  out  1  SDA output enable, active low (0 = pull low)
- reg_addr  out  8  current register pointer
- reg_wdata  out  8  received write byte
- reg_wr  out  1  one-cycle write strobe; reg_addr/reg_wdata valid in the same cycle
- reg_rd  out  1  one-cycle read request; reg_rdata is sampled on the following clk
- reg_rdata  in  8  read data from register bank
- busy  out  1  high from START to STOP
- addr_hit  out  1  one-cycle pulse when the address byte matches (either R/W)

Behaviour:
- Reset and clock: rst is asynchronous, active-high; clk is the clock.
- Reset values:
  - sda_oen=1, sda_o=0, reg_addr=0, reg_wdata=0.
  - reg_wr=0, reg_rd=0, busy=0, addr_hit=0.
  - state=IDLE; synchronisers preset to 1.
- Input conditioning and event detection:
  - Inputs pass through SYNC_STAGES flops; rise/fall events are detected from the last two samples.
  - START/Sr: SDA fall while SCL high. STOP: SDA rise while SCL high.
  - Events take priority over bit sampling in the same cycle.
- Bit handling:
  - Data bits are sampled on SCL rise, MSB first.
  - The slave changes sda_oen only on a detected SCL fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE: START → ADDR, busy=1.
- ADDR: after 8 bits:
  - Match → addr_hit pulse, go ADDR_ACK; sda_oen=0 from the 8th SCL fall to the 9th SCL fall.
  - No match → IGNORE.
- ADDR_ACK, at the 9th SCL fall, branch on the R/W bit:
  - W=0: go to PTR after the first START, or to WDATA if the pointer was already written in this transaction.
  - R=1: pulse reg_rd; load the shift register with reg_rdata; go RDATA.
- PTR: the 8 bits received load reg_addr; ACK as above → WDATA.
- WDATA: each byte:
  - reg_wdata ← byte, reg_wr pulses one cycle after the 8th SCL rise.
  - ACK driven.
  - reg_addr increments (mod 256, wraps 8'hFF→8'h00) after the reg_wr cycle.
- RDATA:
  - Drives the shift-register MSB on each SCL fall: sda_oen = bit (0 drives low, 1 releases).
  - After 8 bits, release SDA → RDATA_ACK; sample the master's ACK on the 9th SCL rise.
- RDATA_ACK:
  - ACK(0): reg_addr+1, reg_rd pulse, reload, → RDATA.
  - NACK(1): reg_addr+1, → IGNORE; SDA stays released.
- IGNORE: SDA released; wait for START/STOP.
- Any state:
  - STOP → IDLE, busy=0, sda_oen=1.
  - Sr → ADDR; reg_addr is kept, so a write-pointer followed by a read works.
- Boundary rules:
  - reg_wr and reg_rd are never asserted in the same cycle.
  - An address mismatch never drives SDA.
  - STOP mid-byte discards the partial byte with no strobe.
  - Reset mid-transfer releases SDA within the same cycle (async).

Optional Feature:
- Macro I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: after synchronisation, SCL and SDA each pass through a 3-sample majority filter; adds 1 clk of input latency and rejects 1-clk spikes.
- Undefined: raw synchronised signals are used; a 1-clk spike on SCL counts as an edge.

Decomposition:
- Package i2c_pkg:
  - State enum constants.
  - I2C_RW_READ/I2C_RW_WRITE bit constants.
  - ACK=1'b0 / NACK=1'b1 constants.
- Sub-module i2c_line_cond: synchroniser, optional filter, and SCL rise/fall plus START/STOP detection. Instantiated once, emitting single-cycle event strobes.

Test Plan:
- Write with pointer:
  - Stimulus: START, 0xA0, 0x10, 0x5A, 0xC3, STOP.
  - Response: addr_hit×1; ACK on all 4 bytes; reg_wr at addr 0x10 data 0x5A, then addr 0x11 data 0xC3; busy falls at STOP.
- Random read:
  - Stimulus: START, 0xA0, 0x20, Sr, 0xA1; reg_rdata=0x3C at 0x20 and 0x7E at 0x21; master ACK then NACK; STOP.
  - Response: bytes 0x3C and 0x7E on SDA; reg_rd×2; no reg_wr.
- Address mismatch:
  - Stimulus: START, 0xB0, 0x01, STOP.
  - Response: sda_oen=1 throughout; no addr_hit, reg_wr or reg_rd.
- Pointer wrap:
  - Stimulus: pointer 0xFF, then writes 0x11, 0x22.
  - Response: reg_wr at 0xFF then 0x00.
- Abort:
  - Stimulus: STOP after 4 data bits of a write byte; then, in a separate run, assert rst while the slave drives ACK.
  - Response: no reg_wr and state IDLE for the STOP case; sda_oen=1 immediately for the rst case.
- Glitch (macro defined):
  - Stimulus: 1-clk SCL low pulse during a data bit.
  - Response: byte received intact.
  - Without the macro, the bench expects a bit-count corruption.
